serial_lu_ctrl: RTL and testbench

Bit-serial sequencer that feeds the team's 1-bit logic unit (AND/NAND/OR/NOR selected by keyA/keyB through mux_2x1 stages) and consumes its single-bit output. It accepts two WIDTH-bit operands and an operation code, presents one bit pair per clock to the LU, shifts the LU result back into a WIDTH-bit result register, and signals completion with a one-cycle done pulse. The LU itself stays purely combinational, outside this block; this block supplies its x, y, keyA, keyB and samples its S.

---
 rtl/serial_lu_pkg.sv | 18 +
 rtl/serial_shift_reg.sv | 36 +++
 rtl/serial_lu_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_lu_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_lu_pkg.sv
// serial_lu_pkg
// Shared definitions for the bit-serial logic-unit sequencer:
//   - OP_* : {keyA,keyB} encodings understood by the 1-bit logic unit
//   - state_t : sequencer FSM states
package serial_lu_pkg;

   localparam logic [1:0] OP_NAND = 2'b00;
   localparam logic [1:0] OP_NOR  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_OR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg
// WIDTH-bit right-shifting register with parallel load.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset (clears q)
//   load     : parallel load of din (has priority over shift)
//   shift    : shift right one place, sin enters at the MSB
//   din      : parallel load data
//   sin      : serial input (MSB side)
//   q        : register contents
//   sout     : serial output (LSB), straight from the register
module serial_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {sin, q[WIDTH-1:1]};
      end
   end

   assign sout = q[0];

endmodule

// File: rtl/serial_lu_ctrl.sv
// serial_lu_ctrl
// Bit-serial sequencer around an external combinational 1-bit logic unit.
// Operands are shifted out LSB first on lu_x/lu_y, the LU answer lu_s is
// shifted back into a result register, and done pulses for one cycle when
// result holds the completed word.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start           : request, accepted only when idle
//   a, b, op        : operands and {keyA,keyB} opcode, latched on acceptance
//   lu_x, lu_y      : current operand bit pair to the LU
//   lu_keyA, lu_keyB: LU function select, held from the latched op
//   lu_s            : LU result bit (combinational from lu_*)
//   busy            : operation in progress (SHIFT or DONE)
//   done            : one-cycle pulse, result valid
//   result          : last completed result
//   zero            : result-is-all-zeros flag (only with SERIAL_LU_ZERO_FLAG_EN)
// Optional feature macro: SERIAL_LU_ZERO_FLAG_EN
module serial_lu_ctrl
   import serial_lu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             lu_x,
   output logic             lu_y,
   output logic             lu_keyA,
   output logic             lu_keyB,
   input  logic             lu_s,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
`ifdef SERIAL_LU_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             shift_en;
   logic [WIDTH-1:0] a_q_unused;
   logic [WIDTH-1:0] b_q_unused;
   logic [WIDTH-1:0] res_q;
   logic             res_sout_unused;

   assign load     = (state == IDLE) && start;
   assign shift_en = (state == SHIFT);

   // Operand shifters: their LSBs drive the LU directly, so lu_x/lu_y are
   // register outputs and settle to 0 once all bits have been shifted out.
   serial_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_en),
      .din   (a),
      .sin   (1'b0),
      .q     (a_q_unused),
      .sout  (lu_x)
   );

   serial_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_en),
      .din   (b),
      .sin   (1'b0),
      .q     (b_q_unused),
      .sout  (lu_y)
   );

   // LU answers enter at the MSB; after WIDTH shifts bit i sits at index i.
   serial_shift_reg #(.WIDTH(WIDTH)) u_res_sh (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_en),
      .din   ('0),
      .sin   (lu_s),
      .q     (res_q),
      .sout  (res_sout_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         lu_keyA <= 1'b0;
         lu_keyB <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
`ifdef SERIAL_LU_ZERO_FLAG_EN
         zero    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lu_keyA <= op[1];
                  lu_keyB <= op[0];
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Counter parks at the last index instead of wrapping.
               if (cnt == LAST) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               result <= res_q;
`ifdef SERIAL_LU_ZERO_FLAG_EN
               zero   <= (res_q == '0);
`endif
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_lu_ctrl.sv
// tb_serial_lu_ctrl
// Scoreboard bench for serial_lu_ctrl (WIDTH=8) with a behavioural 1-bit LU
// closing the loop between lu_* and lu_s.
module tb_serial_lu_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic         lu_x, lu_y, lu_keyA, lu_keyB, lu_s;
   logic         busy, done;
   logic [W-1:0] result;
`ifdef SERIAL_LU_ZERO_FLAG_EN
   logic         zero;
`endif

   always #5 clk = ~clk;

   serial_lu_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .op      (op),
      .lu_x    (lu_x),
      .lu_y    (lu_y),
      .lu_keyA (lu_keyA),
      .lu_keyB (lu_keyB),
      .lu_s    (lu_s),
      .busy    (busy),
      .done    (done),
      .result  (result)
`ifdef SERIAL_LU_ZERO_FLAG_EN
      ,
      .zero    (zero)
`endif
   );

   // 1-bit logic unit: keyA picks the AND/OR group, keyB picks the gate.
   function automatic logic lu_bit(input logic x, input logic y,
                                   input logic ka, input logic kb);
      if (ka) return kb ? (x | y) : (x & y);
      else    return kb ? ~(x | y) : ~(x & y);
   endfunction

   assign lu_s = lu_bit(lu_x, lu_y, lu_keyA, lu_keyB);

   // Word-level reference for a completed operation.
   function automatic logic [W-1:0] ref_word(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [1:0] o);
      case (o)
         2'b00:   return ~(x & y);
         2'b01:   return ~(x | y);
         2'b10:   return x & y;
         default: return x | y;
      endcase
   endfunction

   typedef struct {
      logic [W-1:0] res;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   int           checks  = 0;
   int           errors  = 0;
   int           cyc     = 0;
   int           m_timer = 0;      // cycles of busy still owed; 0 = idle
   logic [1:0]   m_op    = '0;
   logic [W-1:0] m_a     = '0;
   logic [W-1:0] m_b     = '0;
   logic [W-1:0] m_result = '0;
   logic         m_zero  = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock edge plus the model update for the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_timer = 0;
      end else if (m_timer == 0) begin
         if (start) begin
            sb.push_back('{res: ref_word(a, b, op), cyc: cyc + W + 1});
            m_op    = op;
            m_a     = a;
            m_b     = b;
            m_timer = W + 1;
         end
      end else begin
         m_timer--;
      end
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [1:0] iop, input logic [W-1:0] lit,
                         input string name);
      a = ia; b = ib; op = iop; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < W + 4 && m_timer != 0; n++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         op = 2'($urandom);
         tick();
      end
      check({name, "_result"}, result, lit);
      check({name, "_done"}, done, 1'b1);
      tick();
   endtask

   // Monitor: compares every cycle against the model, pops on expected done.
   initial begin
      bit exp_done;
      int idx;
      forever begin
         @(negedge clk);
         exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
         check("done", done, exp_done);
         if (exp_done) begin
            m_result = sb[0].res;
            m_zero   = (sb[0].res == '0);
            void'(sb.pop_front());
         end
         check("busy", busy, m_timer != 0);
         check("result", result, m_result);
`ifdef SERIAL_LU_ZERO_FLAG_EN
         check("zero", zero, m_zero);
`endif
         if (m_timer >= 2) begin
            idx = W + 1 - m_timer;
            check("lu_x", lu_x, m_a[idx]);
            check("lu_y", lu_y, m_b[idx]);
            check("lu_keyA", lu_keyA, m_op[1]);
            check("lu_keyB", lu_keyB, m_op[0]);
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
      repeat (3) tick();
      check("rst_lu_x", lu_x, 1'b0);
      check("rst_lu_y", lu_y, 1'b0);
      check("rst_keyA", lu_keyA, 1'b0);
      check("rst_keyB", lu_keyB, 1'b0);
      rst = 1'b0;

      // Idle after reset, no start.
      repeat (20) tick();

      // Directed operations on the same operands.
      run_op(8'hCA, 8'h53, 2'b10, 8'h42, "and");
      run_op(8'hCA, 8'h53, 2'b11, 8'hDB, "or");
      run_op(8'hCA, 8'h53, 2'b00, 8'hBD, "nand");
      run_op(8'hCA, 8'h53, 2'b01, 8'h24, "nor");
      run_op(8'h0F, 8'hF0, 2'b10, 8'h00, "zero_and");
      run_op(8'h0F, 8'hF0, 2'b11, 8'hFF, "zero_or");

      // start held high: back-to-back, inputs scrambled every cycle.
      start = 1'b1;
      for (int n = 0; n < 45; n++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         op = 2'($urandom);
         tick();
      end
      start = 1'b0;
      repeat (W + 3) tick();

      // Reset in the middle of SHIFT.
      a = 8'h5A; b = 8'hC3; op = 2'b11; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      m_timer = 0; sb.delete(); m_result = '0; m_zero = 1'b0;
      m_op = '0; m_a = '0; m_b = '0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, '0);
      check("abort_lu_x", lu_x, 1'b0);
      check("abort_lu_y", lu_y, 1'b0);
      check("abort_keyA", lu_keyA, 1'b0);
      check("abort_keyB", lu_keyB, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      run_op(8'hA5, 8'h3C, 2'b10, 8'h24, "post_rst");

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         start = ($urandom_range(0, 3) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         op    = 2'($urandom);
         tick();
      end
      start = 1'b0;
      repeat (W + 4) tick();
      check("drain", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
